// File: rtl/vx_mem_chan_perf.sv
// vx_mem_chan_perf
//   Per-channel memory traffic monitor. Snoops the request/response
//   handshakes of NUM_CHANNELS memory ports and keeps, per channel,
//   saturating read/write/latency counters plus an outstanding-read
//   tracker with peak and sticky overflow/underflow flags. One channel,
//   or the all-channel aggregate, is presented on a registered readout.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/ready/rw [N]     request handshake per channel (rw: 1=write)
//   rsp_valid/ready [N]        read response handshake per channel
//   clear                      synchronous clear of counters and sticky flags
//   freeze                     holds reads/writes/latency accumulators
//   rd_sel                     0..N-1 selects a channel, N the aggregate
//   rd_reads/writes/latency    selected counters (registered)
//   rd_pending/peak            selected outstanding and peak outstanding reads
//   rd_err                     selected sticky flags {overflow, underflow}
module vx_mem_chan_perf #(
  parameter int NUM_CHANNELS = 2,
  parameter int CTR_WIDTH    = 44,
  parameter int PEND_WIDTH   = 8,
  parameter int SEL_WIDTH    = $clog2(NUM_CHANNELS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] req_valid,
  input  logic [NUM_CHANNELS-1:0] req_ready,
  input  logic [NUM_CHANNELS-1:0] req_rw,
  input  logic [NUM_CHANNELS-1:0] rsp_valid,
  input  logic [NUM_CHANNELS-1:0] rsp_ready,
  input  logic                    clear,
  input  logic                    freeze,
  input  logic [SEL_WIDTH-1:0]    rd_sel,
  output logic [CTR_WIDTH-1:0]    rd_reads,
  output logic [CTR_WIDTH-1:0]    rd_writes,
  output logic [CTR_WIDTH-1:0]    rd_latency,
  output logic [PEND_WIDTH-1:0]   rd_pending,
  output logic [PEND_WIDTH-1:0]   rd_peak,
  output logic [1:0]              rd_err
);

  localparam int LAT_W  = CTR_WIDTH + 1;
  localparam int SUM_W  = CTR_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int PSUM_W = PEND_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [SEL_WIDTH-1:0] AGG_SEL = SEL_WIDTH'(NUM_CHANNELS);

  logic [CTR_WIDTH-1:0]  reads_a  [NUM_CHANNELS];
  logic [CTR_WIDTH-1:0]  writes_a [NUM_CHANNELS];
  logic [CTR_WIDTH-1:0]  lat_a    [NUM_CHANNELS];
  logic [PEND_WIDTH-1:0] pend_a   [NUM_CHANNELS];
  logic [PEND_WIDTH-1:0] peak_a   [NUM_CHANNELS];
  logic [1:0]            err_a    [NUM_CHANNELS];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic                  rd_fire, wr_fire, rsp_fire;
    logic                  inc, dec, ovf_set, unf_set;
    logic [PEND_WIDTH-1:0] pend_q, pend_nxt, peak_q;
    logic [CTR_WIDTH-1:0]  reads_q, writes_q, lat_q;
    logic [LAT_W-1:0]      lat_sum;
    logic                  ovf_q, unf_q;

    always_comb begin
      rd_fire  = req_valid[c] & req_ready[c] & ~req_rw[c];
      wr_fire  = req_valid[c] & req_ready[c] &  req_rw[c];
      rsp_fire = rsp_valid[c] & rsp_ready[c];
      // a read and a response in the same cycle cancel out
      inc      = rd_fire & ~rsp_fire;
      dec      = rsp_fire & ~rd_fire;
      ovf_set  = inc & (pend_q == PEND_MAX);
      unf_set  = dec & (pend_q == '0);
      pend_nxt = pend_q;
      if (inc && !ovf_set)
        pend_nxt = pend_q + PEND_WIDTH'(1);
      else if (dec && !unf_set)
        pend_nxt = pend_q - PEND_WIDTH'(1);
      // latency accrues the pre-update outstanding count
      lat_sum  = {1'b0, lat_q} + LAT_W'(pend_q);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pend_q   <= '0;
        peak_q   <= '0;
        reads_q  <= '0;
        writes_q <= '0;
        lat_q    <= '0;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
      end else begin
        pend_q <= pend_nxt;
        if (clear) begin
          reads_q  <= '0;
          writes_q <= '0;
          lat_q    <= '0;
          ovf_q    <= 1'b0;
          unf_q    <= 1'b0;
          peak_q   <= pend_nxt;
        end else begin
          ovf_q <= ovf_q | ovf_set;
          unf_q <= unf_q | unf_set;
          if (pend_nxt > peak_q)
            peak_q <= pend_nxt;
          if (!freeze) begin
            if (rd_fire && reads_q != CTR_MAX)
              reads_q <= reads_q + CTR_WIDTH'(1);
            if (wr_fire && writes_q != CTR_MAX)
              writes_q <= writes_q + CTR_WIDTH'(1);
            lat_q <= lat_sum[CTR_WIDTH] ? CTR_MAX : lat_sum[CTR_WIDTH-1:0];
          end
        end
      end
    end

    assign reads_a[c]  = reads_q;
    assign writes_a[c] = writes_q;
    assign lat_a[c]    = lat_q;
    assign pend_a[c]   = pend_q;
    assign peak_a[c]   = peak_q;
    assign err_a[c]    = {ovf_q, unf_q};
  end

  logic [SUM_W-1:0]      sum_reads, sum_writes, sum_lat;
  logic [PSUM_W-1:0]     sum_pend;
  logic [PEND_WIDTH-1:0] agg_peak;
  logic [1:0]            agg_err;
  logic [CTR_WIDTH-1:0]  nxt_reads, nxt_writes, nxt_lat;
  logic [PEND_WIDTH-1:0] nxt_pend, nxt_peak;
  logic [1:0]            nxt_err;

  always_comb begin
    sum_reads  = '0;
    sum_writes = '0;
    sum_lat    = '0;
    sum_pend   = '0;
    agg_peak   = '0;
    agg_err    = '0;
    nxt_reads  = '0;
    nxt_writes = '0;
    nxt_lat    = '0;
    nxt_pend   = '0;
    nxt_peak   = '0;
    nxt_err    = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      sum_reads  = sum_reads  + SUM_W'(reads_a[c]);
      sum_writes = sum_writes + SUM_W'(writes_a[c]);
      sum_lat    = sum_lat    + SUM_W'(lat_a[c]);
      sum_pend   = sum_pend   + PSUM_W'(pend_a[c]);
      if (peak_a[c] > agg_peak)
        agg_peak = peak_a[c];
      agg_err = agg_err | err_a[c];
      if (rd_sel == SEL_WIDTH'(c)) begin
        nxt_reads  = reads_a[c];
        nxt_writes = writes_a[c];
        nxt_lat    = lat_a[c];
        nxt_pend   = pend_a[c];
        nxt_peak   = peak_a[c];
        nxt_err    = err_a[c];
      end
    end
    // out-of-range selects fall through with all-zero readout
    if (rd_sel == AGG_SEL) begin
      nxt_reads  = (|sum_reads[SUM_W-1:CTR_WIDTH])  ? CTR_MAX : sum_reads[CTR_WIDTH-1:0];
      nxt_writes = (|sum_writes[SUM_W-1:CTR_WIDTH]) ? CTR_MAX : sum_writes[CTR_WIDTH-1:0];
      nxt_lat    = (|sum_lat[SUM_W-1:CTR_WIDTH])    ? CTR_MAX : sum_lat[CTR_WIDTH-1:0];
      nxt_pend   = (|sum_pend[PSUM_W-1:PEND_WIDTH]) ? PEND_MAX : sum_pend[PEND_WIDTH-1:0];
      nxt_peak   = agg_peak;
      nxt_err    = agg_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_reads   <= '0;
      rd_writes  <= '0;
      rd_latency <= '0;
      rd_pending <= '0;
      rd_peak    <= '0;
      rd_err     <= '0;
    end else begin
      rd_reads   <= nxt_reads;
      rd_writes  <= nxt_writes;
      rd_latency <= nxt_lat;
      rd_pending <= nxt_pend;
      rd_peak    <= nxt_peak;
      rd_err     <= nxt_err;
    end
  end

endmodule
